// File: rtl/axi_sram_slave_if.sv
// ============================================================================
// Module      : axi_sram_slave_if
// Description : AXI3-style slave-port bundle between the arbiter and the SRAM responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface axi_sram_slave_if;
    logic [3:0]  arid_i;
    logic [31:0] araddr_i;
    logic [7:0]  arlen_i;
    logic [2:0]  arsize_i;
    logic [1:0]  arburst_i;
    logic        arvalid_i;
    logic        arready_o;

    logic [3:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;

    logic [3:0]  awid_i;
    logic [31:0] awaddr_i;
    logic [7:0]  awlen_i;
    logic [2:0]  awsize_i;
    logic [1:0]  awburst_i;
    logic        awvalid_i;
    logic        awready_o;

    logic [3:0]  wid_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wlast_i;
    logic        wvalid_i;
    logic        wready_o;

    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;

    modport master (
        output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
        input  arready_o,
        input  rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
        output rready_i,
        output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        input  awready_o,
        output wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
        input  wready_o,
        input  bid_o, bresp_o, bvalid_o,
        output bready_i
    );

    modport slave (
        input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
        output arready_o,
        output rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
        input  rready_i,
        input  awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        output awready_o,
        input  wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
        output wready_o,
        output bid_o, bresp_o, bvalid_o,
        input  bready_i
    );
endinterface

`default_nettype wire

// File: rtl/axi_sram_slave.sv
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI3-style SRAM responder, one read and one write burst in flight.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axi_sram_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  wire              clk_i,
    input  wire              rst_i,
    axi_sram_slave_if.slave  bus
);

    localparam int          IDXW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN = 32'(DEPTH_WORDS * 4);
    localparam logic [1:0]  c_OKAY = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;

    localparam logic [1:0] R_INIT = 2'd0;
    localparam logic [1:0] R_IDLE = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_INIT = 2'd0;
    localparam logic [1:0] W_IDLE = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    logic [31:0] r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------ read
    logic [1:0]  r_rstate;
    logic [31:0] r_raddr;
    logic [2:0]  r_rsize;
    logic        r_rfixed;
    logic        r_rbad;
    logic [7:0]  r_rleft;
    logic [3:0]  r_rid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rlast;

    logic            w_ar_fire;
    logic            w_r_fire;
    logic            w_rload;
    logic            w_ar_bad;
    logic [31:0]     w_r_step;
    logic [31:0]     w_r_next;
    logic [31:0]     w_rload_addr;
    logic            w_rload_bad;
    logic [31:0]     w_rload_off;
    logic            w_rload_err;
    logic [IDXW-1:0] w_rload_idx;

    assign w_ar_fire    = bus.arvalid_i & (r_rstate == R_IDLE);
    assign w_r_fire     = bus.rready_i & (r_rstate == R_DATA);
    assign w_rload      = w_ar_fire | (w_r_fire & ~r_rlast);
    assign w_ar_bad     = bus.arburst_i[1] | (bus.arsize_i > 3'd2);
    assign w_r_step     = r_rfixed ? 32'd0 : (32'd1 << r_rsize);
    assign w_r_next     = r_raddr + w_r_step;
    // Beat 0 comes straight from the AR channel, later beats from the advanced address
    assign w_rload_addr = w_ar_fire ? bus.araddr_i : w_r_next;
    assign w_rload_bad  = w_ar_fire ? w_ar_bad : r_rbad;
    assign w_rload_off  = w_rload_addr - BASE_ADDR;
    assign w_rload_err  = w_rload_bad | (w_rload_off >= c_SPAN);
    assign w_rload_idx  = IDXW'(w_rload_off >> 2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rstate <= R_INIT;
            r_raddr  <= '0;
            r_rsize  <= '0;
            r_rfixed <= 1'b0;
            r_rbad   <= 1'b0;
            r_rleft  <= '0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
        end else begin
            if (w_rload) begin
                r_raddr <= w_rload_addr;
                r_rdata <= w_rload_err ? 32'd0 : r_mem[w_rload_idx];
                r_rresp <= w_rload_err ? c_SLVERR : c_OKAY;
            end
            case (r_rstate)
                R_INIT: r_rstate <= R_IDLE;
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rid    <= bus.arid_i;
                        r_rsize  <= bus.arsize_i;
                        r_rfixed <= (bus.arburst_i == 2'b00);
                        r_rbad   <= w_ar_bad;
                        r_rleft  <= bus.arlen_i;
                        r_rlast  <= (bus.arlen_i == 8'd0);
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_fire) begin
                        if (r_rlast) begin
                            r_rlast  <= 1'b0;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rleft <= r_rleft - 8'd1;
                            r_rlast <= (r_rleft == 8'd1);
                        end
                    end
                end
                default: r_rstate <= R_INIT;
            endcase
        end
    end

    assign bus.arready_o = (r_rstate == R_IDLE);
    assign bus.rvalid_o  = (r_rstate == R_DATA);
    assign bus.rid_o     = r_rid;
    assign bus.rdata_o   = r_rdata;
    assign bus.rresp_o   = r_rresp;
    assign bus.rlast_o   = r_rlast;

    // ----------------------------------------------------------------- write
    logic [1:0]  r_wstate;
    logic [31:0] r_waddr;
    logic [2:0]  r_wsize;
    logic        r_wfixed;
    logic        r_wbad;
    logic [7:0]  r_wlen;
    logic [8:0]  r_wcnt;
    logic        r_werr;
    logic [3:0]  r_bid;
    logic [1:0]  r_bresp;

    logic            w_aw_fire;
    logic            w_w_fire;
    logic            w_b_fire;
    logic [31:0]     w_w_step;
    logic [31:0]     w_w_off;
    logic            w_w_err;
    logic [IDXW-1:0] w_w_idx;
    logic            w_w_len_bad;
    logic            w_mem_we;
    logic            w_unused;

    assign w_aw_fire   = bus.awvalid_i & (r_wstate == W_IDLE);
    assign w_w_fire    = bus.wvalid_i & (r_wstate == W_DATA);
    assign w_b_fire    = bus.bready_i & (r_wstate == W_RESP);
    assign w_w_step    = r_wfixed ? 32'd0 : (32'd1 << r_wsize);
    assign w_w_off     = r_waddr - BASE_ADDR;
    assign w_w_err     = r_wbad | (w_w_off >= c_SPAN);
    assign w_w_idx     = IDXW'(w_w_off >> 2);
    // r_wcnt is the zero-based index of the current beat, so wlast must land on awlen
    assign w_w_len_bad = (r_wcnt != {1'b0, r_wlen});
    assign w_mem_we    = w_w_fire & ~w_w_err;
    assign w_unused    = ^bus.wid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wstate <= W_INIT;
            r_waddr  <= '0;
            r_wsize  <= '0;
            r_wfixed <= 1'b0;
            r_wbad   <= 1'b0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= '0;
        end else begin
            case (r_wstate)
                W_INIT: r_wstate <= W_IDLE;
                W_IDLE: begin
                    if (w_aw_fire) begin
                        r_waddr  <= bus.awaddr_i;
                        r_wsize  <= bus.awsize_i;
                        r_wfixed <= (bus.awburst_i == 2'b00);
                        r_wbad   <= bus.awburst_i[1] | (bus.awsize_i > 3'd2);
                        r_wlen   <= bus.awlen_i;
                        r_wcnt   <= '0;
                        r_werr   <= 1'b0;
                        r_bid    <= bus.awid_i;
                        r_wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_fire) begin
                        r_waddr <= r_waddr + w_w_step;
                        r_werr  <= r_werr | w_w_err;
                        if (r_wcnt != 9'h1FF) begin
                            r_wcnt <= r_wcnt + 9'd1;
                        end
                        if (bus.wlast_i) begin
                            r_bresp  <= (r_werr | w_w_err | w_w_len_bad) ? c_SLVERR : c_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_fire) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wstrb_i[k]) begin
                    r_mem[w_w_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign bus.awready_o = (r_wstate == W_IDLE);
    assign bus.wready_o  = (r_wstate == W_DATA);
    assign bus.bvalid_o  = (r_wstate == W_RESP);
    assign bus.bid_o     = r_bid;
    assign bus.bresp_o   = r_bresp;

endmodule

`default_nettype wire
